// File: rtl/prco_mem_arbiter.sv
// prco_mem_arbiter: three-requester arbiter for one single-port synchronous memory.
// Requesters are fetch (0), data (1) and UART loader (2). The default build uses fixed priority 1 > 2 > 0.
// Define PRCO_ARB_RR_EN to switch to round-robin arbitration.
// Each transaction runs IDLE -> ISSUE for a write, or IDLE -> ISSUE -> RDWAIT for a read.
module prco_mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [2:0]      i_req,
    input  logic [2:0]      i_we,
    input  logic [3*AW-1:0] i_addr,
    input  logic [3*DW-1:0] i_din,
    output logic [2:0]      q_ack,
    output logic [2:0]      q_rvalid,
    output logic [DW-1:0]   q_rdata,
    output logic [AW-1:0]   q_mem_addr,
    output logic            q_mem_we,
    output logic [DW-1:0]   q_mem_din,
    input  logic [DW-1:0]   i_mem_dout,
    output logic            q_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
    state_t          state_q, state_d;
    logic [1:0]      win_q, win_d, sel;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic [2:0]      win_oh;
`ifdef PRCO_ARB_RR_EN
    logic [1:0]      ptr_q, ptr_d, p1, p2;
    assign p1 = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
    assign p2 = ptr_q == 2'd0 ? 2'd2 : ptr_q - 2'd1;
    // first requester at or after the pointer wins; pointer moves past each winner
    always_comb begin
        sel   = i_req[ptr_q] ? ptr_q : i_req[p1] ? p1 : p2;
        ptr_d = (state_q == IDLE && |i_req) ? (sel == 2'd2 ? 2'd0 : sel + 2'd1) : ptr_q;
    end
    // round-robin pointer register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ptr_q <= 2'd0;
        else         ptr_q <= ptr_d;
    end
`else
    // fixed priority: data, then loader, then fetch
    always_comb sel = i_req[1] ? 2'd1 : i_req[2] ? 2'd2 : 2'd0;
`endif
    // next state; the winner's request is captured only at the grant edge
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: if (|i_req) begin
                state_d = ISSUE;
                win_d   = sel;
                we_d    = i_we[sel];
                addr_d  = i_addr[sel*AW +: AW];
                din_d   = i_din[sel*DW +: DW];
            end
            ISSUE:   state_d = we_q ? IDLE : RDWAIT;
            default: state_d = IDLE;
        endcase
    end
    // state and captured transaction registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            win_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end
    // outputs decode from state; address and data hold between transactions
    always_comb begin
        win_oh     = 3'b001 << win_q;
        q_ack      = state_q == ISSUE  ? win_oh : 3'b000;
        q_rvalid   = state_q == RDWAIT ? win_oh : 3'b000;
        q_rdata    = state_q == RDWAIT ? i_mem_dout : '0;
        q_mem_we   = state_q == ISSUE && we_q;
        q_mem_addr = addr_q;
        q_mem_din  = din_q;
        q_busy     = state_q != IDLE;
    end
endmodule

// File: tb/tb_prco_mem_arbiter.sv
// tb_prco_mem_arbiter: directed bench for prco_mem_arbiter with a behavioural memory
module tb_prco_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    typedef struct {
        int          idx;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;
    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [2:0]      i_req = '0;
    logic [2:0]      i_we = '0;
    logic [3*AW-1:0] i_addr = '0;
    logic [3*DW-1:0] i_din = '0;
    logic [2:0]      q_ack, q_rvalid;
    logic [DW-1:0]   q_rdata, q_mem_din, i_mem_dout;
    logic [AW-1:0]   q_mem_addr;
    logic            q_mem_we, q_busy;
    logic [DW-1:0]   mem [0:255];
    int              checks = 0;
    int              failures = 0;
    vec_t            vecs [10];
    int              exp_order [6];
    int              order [6];

    always #5 i_clk = ~i_clk;

    prco_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_din(i_din), .q_ack(q_ack), .q_rvalid(q_rvalid),
        .q_rdata(q_rdata), .q_mem_addr(q_mem_addr), .q_mem_we(q_mem_we),
        .q_mem_din(q_mem_din), .i_mem_dout(i_mem_dout), .q_busy(q_busy)
    );

    always @(posedge i_clk) begin
        if (q_mem_we) mem[q_mem_addr[7:0]] <= q_mem_din;
        i_mem_dout <= mem[q_mem_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, q_ack, 0);
        chk({tag, "_rvalid"}, q_rvalid, 0);
        chk({tag, "_rdata"}, q_rdata, 0);
        chk({tag, "_addr"}, q_mem_addr, 0);
        chk({tag, "_we"}, q_mem_we, 0);
        chk({tag, "_din"}, q_mem_din, 0);
        chk({tag, "_busy"}, q_busy, 0);
    endtask

    task automatic do_txn(input vec_t v);
        @(posedge i_clk); #1;
        i_req[v.idx] = 1'b1;
        i_we[v.idx] = v.we;
        i_addr[v.idx*AW +: AW] = v.addr;
        i_din[v.idx*DW +: DW] = v.din;
        @(negedge i_clk);
        chk("idle_busy", q_busy, 0);
        @(negedge i_clk);
        chk("issue_ack", q_ack, 3'b001 << v.idx);
        chk("issue_we", q_mem_we, v.we);
        chk("issue_addr", q_mem_addr, v.addr);
        chk("issue_busy", q_busy, 1);
        if (v.we) chk("issue_din", q_mem_din, v.din);
        i_req = '0;
        @(negedge i_clk);
        if (v.we) begin
            chk("wr_rvalid", q_rvalid, 0);
            chk("wr_we_off", q_mem_we, 0);
            chk("wr_busy", q_busy, 0);
        end else begin
            chk("rd_rvalid", q_rvalid, 3'b001 << v.idx);
            chk("rd_data", q_rdata, v.exp);
            chk("rd_busy", q_busy, 1);
            chk("rd_we", q_mem_we, 0);
        end
    endtask

    initial begin
        int n;
        logic seen2;
        logic [2:0] first;
        vecs[0] = '{1, 1'b1, 16'h0004, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 1'b0, 16'h0004, 16'h0000, 16'hBEEF};
        vecs[2] = '{1, 1'b1, 16'h0010, 16'h1234, 16'h0000};
        vecs[3] = '{0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[4] = '{2, 1'b1, 16'h0020, 16'hA5A5, 16'h0000};
        vecs[5] = '{1, 1'b0, 16'h0020, 16'h0000, 16'hA5A5};
        vecs[6] = '{2, 1'b0, 16'h0004, 16'h0000, 16'hBEEF};
        vecs[7] = '{1, 1'b1, 16'h0030, 16'h0F0F, 16'h0000};
        vecs[8] = '{0, 1'b0, 16'h0030, 16'h0000, 16'h0F0F};
        vecs[9] = '{2, 1'b0, 16'h0010, 16'h0000, 16'h1234};
`ifdef PRCO_ARB_RR_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{1, 1, 1, 1, 1, 1};
`endif
        repeat (2) @(negedge i_clk);
        chk_zero("reset");
        i_reset = 1'b0;
        for (int i = 0; i < 10; i++) do_txn(vecs[i]);

        // all three requesters read continuously
        @(negedge i_clk); i_reset = 1'b1;
        @(negedge i_clk); i_reset = 1'b0;
        @(posedge i_clk); #1;
        i_req = 3'b111;
        i_we = 3'b000;
        i_addr = {16'h0020, 16'h0010, 16'h0004};
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge i_clk);
            chk("ack_onehot", $countones(q_ack) <= 1, 1);
            chk("rvalid_onehot", $countones(q_rvalid) <= 1, 1);
            if (q_ack != 3'b000) begin
                order[n] = q_ack[2] ? 2 : q_ack[1] ? 1 : 0;
                n++;
            end
        end
        i_req = '0;
        chk("grant_count", n, 6);
        for (int i = 0; i < 6; i++) chk("grant_order", order[i], exp_order[i]);
        repeat (3) @(negedge i_clk);

        // reset during RDWAIT aborts the read; the held request reissues
        @(posedge i_clk); #1;
        i_req = 3'b010;
        i_we = 3'b000;
        i_addr[AW +: AW] = 16'h0010;
        @(negedge i_clk); @(negedge i_clk);
        chk("abort_ack", q_ack, 3'b010);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        #1;
        chk_zero("abort");
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("abort_no_rvalid", q_rvalid, 0);
        @(negedge i_clk);
        chk("reissue_ack", q_ack, 3'b010);
        chk("reissue_rvalid0", q_rvalid, 0);
        i_req = '0;
        @(negedge i_clk);
        chk("reissue_rvalid", q_rvalid, 3'b010);
        chk("reissue_data", q_rdata, 16'h1234);

        // loader drops its request while data holds the bus; fetch goes next
        @(posedge i_clk); #1;
        i_req = 3'b010;
        i_addr[AW +: AW] = 16'h0020;
        @(negedge i_clk); @(negedge i_clk);
        chk("drop_data_ack", q_ack, 3'b010);
        i_req = 3'b101;
        i_addr[2*AW +: AW] = 16'h0004;
        i_addr[0 +: AW] = 16'h0010;
        @(negedge i_clk);
        chk("drop_data_rvalid", q_rvalid, 3'b010);
        chk("drop_data_rdata", q_rdata, 16'hA5A5);
        i_req = 3'b001;
        seen2 = 1'b0;
        first = 3'b000;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (q_ack[2]) seen2 = 1'b1;
            if (q_ack != 3'b000 && first == 3'b000) first = q_ack;
            if (q_ack[0]) i_req = '0;
        end
        chk("drop_no_loader_ack", seen2, 0);
        chk("drop_fetch_next", first, 3'b001);

        // address and data changes after the grant edge are ignored
        @(posedge i_clk); #1;
        i_req = 3'b010;
        i_we = 3'b010;
        i_addr[AW +: AW] = 16'h0040;
        i_din[DW +: DW] = 16'h7777;
        @(posedge i_clk); #1;
        i_addr[AW +: AW] = 16'h0050;
        i_din[DW +: DW] = 16'h8888;
        @(negedge i_clk);
        chk("late_ack", q_ack, 3'b010);
        chk("late_we", q_mem_we, 1);
        chk("late_addr", q_mem_addr, 16'h0040);
        chk("late_din", q_mem_din, 16'h7777);
        i_req = '0;
        i_we = '0;
        do_txn('{0, 1'b0, 16'h0040, 16'h0000, 16'h7777});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
